// File: rtl/div_pkg.sv
// Shared types and helpers for the non-restoring divider.
//   state_t  : control FSM states
//   iter_w() : width of a down-counter that must hold the value n
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic int iter_w(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/nr_div_step.sv
// One combinational non-restoring division iteration.
// Ports:
//   a_in  / a_out : partial remainder, P_WIDTH+1 bits, two's complement
//   q_in  / q_out : quotient shift register, P_WIDTH bits
//   m             : divisor magnitude, P_WIDTH bits (zero-extended internally)
module nr_div_step #(
    parameter int P_WIDTH = 32
) (
    input  logic [P_WIDTH:0]   a_in,
    input  logic [P_WIDTH-1:0] q_in,
    input  logic [P_WIDTH-1:0] m,
    output logic [P_WIDTH:0]   a_out,
    output logic [P_WIDTH-1:0] q_out
);
    logic [P_WIDTH:0] a_shift;
    logic [P_WIDTH:0] m_ext;

    assign m_ext   = {1'b0, m};
    assign a_shift = {a_in[P_WIDTH-1:0], q_in[P_WIDTH-1]};
    // Add/subtract is chosen by the sign of A before the shift; the shifted
    // value may wrap, but the sum always lands back in range [-M, M).
    assign a_out   = a_in[P_WIDTH] ? (a_shift + m_ext) : (a_shift - m_ext);
    assign q_out   = {q_in[P_WIDTH-2:0], ~a_out[P_WIDTH]};

endmodule

// File: rtl/nr_divider_hs.sv
// Iterative non-restoring signed/unsigned integer divider with valid/ready
// handshakes on request and result sides, tag pass-through and
// divide-by-zero / signed-overflow flags.
// Ports:
//   clk, rst_n                     : clock, asynchronous active-low reset
//   in_valid/in_ready              : request handshake (accept only in IDLE)
//   in_signed, in_dividend,
//   in_divisor, in_tag             : request payload
//   out_valid/out_ready            : result handshake, result held until taken
//   out_quotient, out_remainder,
//   out_tag, out_div_zero,
//   out_overflow                   : result payload (all registered)
module nr_divider_hs
    import div_pkg::*;
#(
    parameter int P_WIDTH          = 32,
    parameter int P_BITS_PER_CYCLE = 1,
    parameter int P_TAG_W          = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_signed,
    input  logic [P_WIDTH-1:0] in_dividend,
    input  logic [P_WIDTH-1:0] in_divisor,
    input  logic [P_TAG_W-1:0] in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [P_WIDTH-1:0] out_quotient,
    output logic [P_WIDTH-1:0] out_remainder,
    output logic [P_TAG_W-1:0] out_tag,
    output logic               out_div_zero,
    output logic               out_overflow
);
    localparam int N      = P_WIDTH / P_BITS_PER_CYCLE;
    localparam int ITER_W = iter_w(N);
    localparam logic [P_WIDTH-1:0] MIN_VAL = {1'b1, {(P_WIDTH-1){1'b0}}};

    if ((P_WIDTH % P_BITS_PER_CYCLE) != 0 || P_WIDTH < 4) begin : g_bad_param
        $error("nr_divider_hs: P_WIDTH must be >=4 and a multiple of P_BITS_PER_CYCLE");
    end

    state_t              state_reg, state_next;
    logic [P_WIDTH:0]    a_reg;
    logic [P_WIDTH-1:0]  q_reg;
    logic [P_WIDTH-1:0]  m_reg;
    logic [ITER_W-1:0]   iter_reg;
    logic                neg_q_reg;
    logic                neg_r_reg;
    logic                out_valid_reg;
    logic [P_WIDTH-1:0]  quotient_reg;
    logic [P_WIDTH-1:0]  remainder_reg;
    logic [P_TAG_W-1:0]  tag_reg;
    logic                div_zero_reg;
    logic                overflow_reg;

    // Request decode (only meaningful when accepting)
    logic                accept;
    logic                result_taken;
    logic                dvd_neg, dvs_neg;
    logic [P_WIDTH-1:0]  dvd_mag, dvs_mag;
    logic                is_zero, is_ovf;

    assign accept       = in_valid && (state_reg == IDLE);
    assign result_taken = (state_reg == DONE) && out_valid_reg && out_ready;
    assign dvd_neg      = in_signed & in_dividend[P_WIDTH-1];
    assign dvs_neg      = in_signed & in_divisor[P_WIDTH-1];
    // Negating MIN yields 2^(P_WIDTH-1), which is the correct unsigned magnitude.
    assign dvd_mag      = dvd_neg ? (-in_dividend) : in_dividend;
    assign dvs_mag      = dvs_neg ? (-in_divisor)  : in_divisor;
    assign is_zero      = (in_divisor == '0);
    assign is_ovf       = in_signed && (in_dividend == MIN_VAL) && (in_divisor == '1);

    // Unrolled iteration chain
    logic [P_WIDTH:0]   a_chain [0:P_BITS_PER_CYCLE];
    logic [P_WIDTH-1:0] q_chain [0:P_BITS_PER_CYCLE];

    assign a_chain[0] = a_reg;
    assign q_chain[0] = q_reg;

    for (genvar gi = 0; gi < P_BITS_PER_CYCLE; gi++) begin : g_step
        nr_div_step #(.P_WIDTH(P_WIDTH)) u_step (
            .a_in  (a_chain[gi]),
            .q_in  (q_chain[gi]),
            .m     (m_reg),
            .a_out (a_chain[gi+1]),
            .q_out (q_chain[gi+1])
        );
    end

    // Final correction: restore a negative remainder, then apply signs.
    // The restored remainder is in [0, M) so P_WIDTH-bit arithmetic suffices.
    logic [P_WIDTH-1:0] rem_mag, quo_fix, rem_fix;
    assign rem_mag = a_reg[P_WIDTH-1:0] + (a_reg[P_WIDTH] ? m_reg : '0);
    assign quo_fix = neg_q_reg ? (-q_reg)   : q_reg;
    assign rem_fix = neg_r_reg ? (-rem_mag) : rem_mag;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = (is_zero || is_ovf) ? DONE : CALC;
            CALC: if (iter_reg == ITER_W'(1)) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: if (result_taken) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            a_reg         <= '0;
            q_reg         <= '0;
            m_reg         <= '0;
            iter_reg      <= '0;
            neg_q_reg     <= 1'b0;
            neg_r_reg     <= 1'b0;
            out_valid_reg <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            tag_reg       <= '0;
            div_zero_reg  <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            // Valid rises one cycle after entering DONE, giving the same
            // extra register stage for special and normal results.
            out_valid_reg <= (state_reg == DONE) && !result_taken;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        a_reg        <= '0;
                        q_reg        <= dvd_mag;
                        m_reg        <= dvs_mag;
                        iter_reg     <= ITER_W'(N);
                        neg_q_reg    <= dvd_neg ^ dvs_neg;
                        neg_r_reg    <= dvd_neg;
                        tag_reg      <= in_tag;
                        div_zero_reg <= is_zero;
                        overflow_reg <= is_ovf;
                        if (is_zero) begin
                            quotient_reg  <= '1;
                            remainder_reg <= in_dividend;
                        end else if (is_ovf) begin
                            quotient_reg  <= MIN_VAL;
                            remainder_reg <= '0;
                        end
                    end
                end
                CALC: begin
                    a_reg    <= a_chain[P_BITS_PER_CYCLE];
                    q_reg    <= q_chain[P_BITS_PER_CYCLE];
                    iter_reg <= iter_reg - ITER_W'(1);
                end
                FIX: begin
                    quotient_reg  <= quo_fix;
                    remainder_reg <= rem_fix;
                end
                default: ;
            endcase
        end
    end

    assign in_ready      = (state_reg == IDLE);
    assign out_valid     = out_valid_reg;
    assign out_quotient  = quotient_reg;
    assign out_remainder = remainder_reg;
    assign out_tag       = tag_reg;
    assign out_div_zero  = div_zero_reg;
    assign out_overflow  = overflow_reg;

endmodule

// File: tb/tb_nr_divider_hs.sv
module tb_nr_divider_hs;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_signed;
    logic [31:0] in_dividend;
    logic [31:0] in_divisor;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_quotient;
    logic [31:0] out_remainder;
    logic [3:0]  out_tag;
    logic        out_div_zero;
    logic        out_overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nr_divider_hs #(.P_WIDTH(32), .P_BITS_PER_CYCLE(1), .P_TAG_W(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_signed     (in_signed),
        .in_dividend   (in_dividend),
        .in_divisor    (in_divisor),
        .in_tag        (in_tag),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_quotient  (out_quotient),
        .out_remainder (out_remainder),
        .out_tag       (out_tag),
        .out_div_zero  (out_div_zero),
        .out_overflow  (out_overflow)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and consume its result; called at #1 after a posedge.
    task automatic run_op(input string name, input logic sg, input logic [31:0] dvd,
                          input logic [31:0] dvs, input logic [3:0] tg,
                          input logic [31:0] exp_q, input logic [31:0] exp_r,
                          input logic exp_dz, input logic exp_ov, input int exp_lat);
        int lat;
        check({name, ".in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1; in_signed = sg; in_dividend = dvd; in_divisor = dvs; in_tag = tg;
        tick();
        in_valid = 1'b0; in_dividend = '0; in_divisor = '0; in_tag = '0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
        $display("op %s: signed=%0b %h / %h -> q=%h r=%h tag=%0d dz=%0b ov=%0b lat=%0d",
                 name, sg, dvd, dvs, out_quotient, out_remainder, out_tag, out_div_zero, out_overflow, lat);
        check({name, ".latency"},   64'(lat),           64'(exp_lat));
        check({name, ".quotient"},  64'(out_quotient),  64'(exp_q));
        check({name, ".remainder"}, 64'(out_remainder), 64'(exp_r));
        check({name, ".tag"},       64'(out_tag),       64'(tg));
        check({name, ".div_zero"},  64'(out_div_zero),  64'(exp_dz));
        check({name, ".overflow"},  64'(out_overflow),  64'(exp_ov));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({name, ".valid_drop"}, 64'(out_valid), 64'd0);
        check({name, ".ready_back"}, 64'(in_ready),  64'd1);
    endtask

    initial begin
        logic [31:0] dvd, dvs, q_hold, r_hold;
        logic        sg;
        logic [3:0]  tg;
        longint      a, b;

        rst_n = 1'b0; in_valid = 1'b0; in_signed = 1'b0; in_dividend = '0;
        in_divisor = '0; in_tag = '0; out_ready = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        check("reset.out_valid", 64'(out_valid),     64'd0);
        check("reset.in_ready",  64'(in_ready),      64'd1);
        check("reset.quotient",  64'(out_quotient),  64'd0);
        check("reset.remainder", 64'(out_remainder), 64'd0);
        check("reset.tag",       64'(out_tag),       64'd0);
        check("reset.flags",     64'({out_div_zero, out_overflow}), 64'd0);

        // Directed vectors (normal results: 34 cycles, special: 1 cycle)
        run_op("u100_7",    1'b0, 32'd100,        32'd7,          4'd3,  32'd14,         32'd2,          1'b0, 1'b0, 34);
        run_op("s-7_2",     1'b1, 32'hFFFFFFF9,   32'd2,          4'd5,  32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, 1'b0, 34);
        run_op("s7_-2",     1'b1, 32'd7,          32'hFFFFFFFE,   4'd6,  32'hFFFFFFFD,   32'd1,          1'b0, 1'b0, 34);
        run_op("s-7_-2",    1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   4'd7,  32'd3,          32'hFFFFFFFF,   1'b0, 1'b0, 34);
        run_op("u_div0",    1'b0, 32'h1234,       32'd0,          4'd8,  32'hFFFFFFFF,   32'h1234,       1'b1, 1'b0, 1);
        run_op("s_div0",    1'b1, 32'h1234,       32'd0,          4'd9,  32'hFFFFFFFF,   32'h1234,       1'b1, 1'b0, 1);
        run_op("s_ovf",     1'b1, 32'h80000000,   32'hFFFFFFFF,   4'd10, 32'h80000000,   32'd0,          1'b0, 1'b1, 1);
        run_op("u_min_m1",  1'b0, 32'h80000000,   32'hFFFFFFFF,   4'd11, 32'd0,          32'h80000000,   1'b0, 1'b0, 34);
        run_op("u_max_1",   1'b0, 32'hFFFFFFFF,   32'd1,          4'd12, 32'hFFFFFFFF,   32'd0,          1'b0, 1'b0, 34);
        run_op("u_max_max", 1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   4'd13, 32'd1,          32'd0,          1'b0, 1'b0, 34);
        run_op("u5_10",     1'b0, 32'd5,          32'd10,         4'd14, 32'd0,          32'd5,          1'b0, 1'b0, 34);
        run_op("s_min_2",   1'b1, 32'h80000000,   32'd2,          4'd15, 32'hC0000000,   32'd0,          1'b0, 1'b0, 34);
        run_op("s_min_min", 1'b1, 32'h80000000,   32'h80000000,   4'd1,  32'd1,          32'd0,          1'b0, 1'b0, 34);

        // Result hold with out_ready low; a competing request must be refused
        in_valid = 1'b1; in_signed = 1'b0; in_dividend = 32'd1000; in_divisor = 32'd3; in_tag = 4'd2;
        tick();
        in_dividend = 32'd50; in_divisor = 32'd5; in_tag = 4'd9;   // stays valid: must not be taken
        for (int i = 0; i < 40 && !out_valid; i++) tick();
        check("hold.quotient",  64'(out_quotient),  64'd333);
        check("hold.remainder", 64'(out_remainder), 64'd1);
        q_hold = out_quotient; r_hold = out_remainder;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold.valid",    64'(out_valid),     64'd1);
            check("hold.in_ready", 64'(in_ready),      64'd0);
            check("hold.q_stable", 64'(out_quotient),  64'(q_hold));
            check("hold.r_stable", 64'(out_remainder), 64'(r_hold));
            check("hold.tag",      64'(out_tag),       64'd2);
        end
        $display("stall: held q=%h r=%h tag=%0d for 10 cycles", out_quotient, out_remainder, out_tag);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        repeat (3) tick();
        check("hold.no_extra", 64'(out_valid), 64'd0);
        check("hold.idle",     64'(in_ready),  64'd1);

        // Random operations against a 64-bit reference using the language operators
        for (int n = 0; n < 40; n++) begin
            sg  = 1'($urandom_range(0, 1));
            dvd = $urandom;
            dvs = $urandom_range(0, 1) ? $urandom : ($urandom & 32'h000000FF);
            if (dvs == 32'd0) dvs = 32'd1;
            if (sg && dvd == 32'h80000000 && dvs == 32'hFFFFFFFF) dvs = 32'd1;
            tg = 4'($urandom_range(0, 15));
            if (sg) begin
                a = longint'($signed(dvd));
                b = longint'($signed(dvs));
            end else begin
                a = longint'({32'd0, dvd});
                b = longint'({32'd0, dvs});
            end
            run_op("rand", sg, dvd, dvs, tg, 32'(a / b), 32'(a % b), 1'b0, 1'b0, 34);
        end

        // Reset in the middle of CALC aborts the operation
        in_valid = 1'b1; in_signed = 1'b0; in_dividend = 32'd999; in_divisor = 32'd9; in_tag = 4'd4;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        check("abort.busy", 64'(in_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        check("abort.valid_low", 64'(out_valid), 64'd0);
        check("abort.ready_hi",  64'(in_ready),  64'd1);
        tick();
        rst_n = 1'b1;
        check("abort.quotient", 64'(out_quotient), 64'd0);
        repeat (40) tick();
        check("abort.no_result", 64'(out_valid), 64'd0);
        check("abort.idle",      64'(in_ready),  64'd1);
        $display("abort: out_valid=%0b in_ready=%0b after mid-op reset", out_valid, in_ready);

        // Design still works after the abort
        run_op("post_rst", 1'b0, 32'd81, 32'd9, 4'd6, 32'd9, 32'd0, 1'b0, 1'b0, 34);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
